// File: rtl/ctc_int_arb.sv
// ctc_int_arb: interrupt scheduler for a Z80 CTC that latches zero-count events, drives int_n and the IM2 vector, and tracks in-service state until RETI.
// Compile-time option: CTC_INT_ARB_AUTO_EOI_EN removes in-service tracking, so ack ends the interrupt and the RETI snoop has no effect.
module ctc_int_arb #(
    parameter int DWID = 8,
    parameter int NCH  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  zc_to,
    input  logic [NCH-1:0]  int_en,
    input  logic [DWID-1:0] vec_base,
    input  logic            m1_n,
    input  logic            iorq_n,
    input  logic            rd_n,
    input  logic [DWID-1:0] din,
    input  logic            iei,
    output logic            ieo,
    output logic            int_n,
    output logic [DWID-1:0] dout,
    output logic            oe_n,
    output logic [NCH-1:0]  irq_pending,
    output logic [NCH-1:0]  in_service
);

    typedef enum logic [0:0] {RETI_IDLE, RETI_GOT_ED} reti_state_t;
    reti_state_t state, state_nxt;

    logic [NCH-1:0]  pending, eligible, ack_set, reti_clr, pend_nxt, insv_nxt;
    logic [DWID-1:0] din_samp;
    logic [1:0]      ch;
    logic            ack, ack_d, ack_take;
    logic            fetch, fetch_d, fetch_end, reti;
    logic            blocked;
    logic            unused_vec_lsbs;

    assign unused_vec_lsbs = ^vec_base[2:0];

    assign ack       = ~m1_n & ~iorq_n;
    assign ack_take  = ack & ~ack_d & iei & (|eligible);
    assign fetch     = ~m1_n & ~rd_n & iorq_n;
    assign fetch_end = fetch_d & ~fetch;

    assign irq_pending = pending;

`ifdef CTC_INT_ARB_AUTO_EOI_EN
    assign ieo = ~reset & iei & ~(|pending);
`else
    // Held low during reset so the chain is quiet until the block is released.
    assign ieo = ~reset & iei & ~(|in_service) & ~(|pending);
`endif

    // A channel is blocked by its own or any higher-priority in-service flag.
    always_comb begin
        blocked  = 1'b0;
        eligible = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
`ifdef CTC_INT_ARB_AUTO_EOI_EN
            eligible[i] = pending[i];
`else
            blocked     = blocked | in_service[i];
            eligible[i] = pending[i] & ~blocked;
`endif
        end
    end

    always_comb begin
        ch = '0;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (eligible[i-1]) begin
                ch = 2'(i - 1);
            end
        end
    end

    always_comb begin
        ack_set  = ack_take ? (eligible & (-eligible)) : '0;
        reti_clr = (reti && iei) ? (in_service & (-in_service)) : '0;
        // Set wins over ack-clear; a disabled channel is dropped regardless.
        pend_nxt = ((pending & ~ack_set) | (zc_to & int_en)) & int_en;
`ifdef CTC_INT_ARB_AUTO_EOI_EN
        insv_nxt = '0;
`else
        insv_nxt = (in_service & ~reti_clr) | ack_set;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RETI_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (fetch_end) begin
            unique case (state)
                RETI_IDLE:   state_nxt = (din_samp == DWID'(8'hED)) ? RETI_GOT_ED : RETI_IDLE;
                RETI_GOT_ED: state_nxt = (din_samp == DWID'(8'hED)) ? RETI_GOT_ED : RETI_IDLE;
                default:     state_nxt = RETI_IDLE;
            endcase
        end
    end

    always_comb begin
        reti = 1'b0;
        if (fetch_end && state == RETI_GOT_ED && din_samp == DWID'(8'h4D)) begin
            reti = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= '0;
            in_service <= '0;
            int_n      <= 1'b1;
            dout       <= '0;
            oe_n       <= 1'b1;
            ack_d      <= 1'b0;
            fetch_d    <= 1'b0;
            din_samp   <= '0;
        end else begin
            pending    <= pend_nxt;
            in_service <= insv_nxt;
            int_n      <= ~(iei & (|eligible));
            ack_d      <= ack;
            fetch_d    <= fetch;
            if (fetch) begin
                din_samp <= din;
            end
            if (ack_take) begin
                dout <= {vec_base[DWID-1:3], ch, 1'b0};
                oe_n <= 1'b0;
            end else begin
                dout <= '0;
                oe_n <= 1'b1;
            end
        end
    end

endmodule
